zombie_wave_scheduler: RTL and testbench
========================================

Name: zombie_wave_scheduler

Overview:
Game-level controller for the lawn datapath. Owns the one-hot level state machine (I, L1, NL2, L2, NL3, L3, DoneL, DoneW) and the shared game tick. It schedules zombie spawns into the five lanes over a valid/ready handshake and counts kills. It issues level_reset pulses that clear datapath positions, and decides win or lose.

Parameters:
TICK_DIV, 500000, clk cycles per game tick.
GAP_L1, 120, ticks between spawns in L1.
GAP_L2, 80, ticks between spawns in L2.
GAP_L3, 50, ticks between spawns in L3.
ZOMBIES_PER_LEVEL, 5, spawns and kills required per level (1..7).
INTERMISSION, 180, ticks spent in NL2/NL3 before the next level.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse from debounced select button
lane_busy  in  5  bit n = lane n holds a live zombie
zombie_killed  in  5  one-cycle pulse per lane when that zombie dies
zombie_reached_end  in  1  level pulse: any zombie crossed x=0
spawn_ready  in  1  datapath accepts spawn this cycle
spawn_valid  out  1  spawn request pending
spawn_lane  out  3  lane 0..4 for the pending spawn
game_tick  out  1  one-cycle pulse every TICK_DIV cycles
state  out  8  one-hot {DoneW,DoneL,L3,NL3,L2,NL2,L1,I}
spawned_count  out  3  spawns accepted this level
killed_count  out  3  kills this level
level_reset  out  1  one-cycle pulse to clear datapath

Behaviour:
- Reset (clk edge with reset=1) sets:
  - state=I (8'b0000_0001), spawn_valid=0, spawn_lane=0, game_tick=0.
  - spawned_count=0, killed_count=0, level_reset=1 (one cycle only).
  - Tick and gap counters cleared; round-robin pointer=0.
  - Reset mid-handshake drops the request with no count.
- Tick: counter 0..TICK_DIV-1, free-running in every state. game_tick=1 in the cycle after the counter reaches TICK_DIV-1, then the counter wraps to 0.
- Transitions (evaluated every cycle, first match wins):
  - I: start -> L1.
  - L1/L2/L3:
    - zombie_reached_end -> DoneL. Lose wins over simultaneous level completion.
    - Else, if killed_count==ZOMBIES_PER_LEVEL and spawned_count==ZOMBIES_PER_LEVEL: L1->NL2, L2->NL3, L3->DoneW.
  - NL2/NL3: after INTERMISSION game_ticks, or on start (skip), -> L2/L3.
  - DoneL/DoneW: start -> I.
- level_reset: one-cycle pulse in the cycle after entering any of NL2, NL3, DoneL, DoneW, I. Entering any state also clears spawned_count, killed_count and the gap counter, and drops spawn_valid.
- Spawn scheduling (only in L1/L2/L3):
  - Gap counter increments on game_tick, 8 bits, saturating.
  - Selection fires when all hold: gap >= GAP_Lx, spawned_count < ZOMBIES_PER_LEVEL, spawn_valid=0.
  - Selection scans lanes ptr, ptr+1, ... (mod 5) for the first lane with lane_busy=0.
  - If one is found: register spawn_lane and set spawn_valid=1 next cycle.
  - If all 5 are busy: no request; retry every cycle.
  - spawn_lane is held stable while spawn_valid=1 and spawn_ready=0.
  - Handshake (valid and ready same cycle) does all of: spawn_valid=0; spawned_count+1; gap counter=0; ptr=(spawn_lane+1) mod 5.
  - First spawn of a level occurs GAP_Lx ticks after level entry.
- Kills: only in L states. killed_count += popcount(zombie_killed), so multiple simultaneous lanes all count. Saturates at ZOMBIES_PER_LEVEL. Kill pulses in any other state are ignored.
- zombie_reached_end is ignored outside L states.
- Completion check uses registered counts, so the transition occurs one cycle after the final kill is counted.

Test Plan:
- Reset: hold reset 2 cycles, TICK_DIV=4 -> state=01h, spawn_valid=0, counts 0, level_reset=1 one cycle; game_tick pulses every 4 cycles.
- Level 1 spawns: TICK_DIV=4, GAP_L1=2, ready tied 1, lane_busy=0, start -> state=02h; spawns at ticks 2,4,6,8,10 on lanes 0,1,2,3,4; spawned_count stops at 5.
- Backpressure/busy: lane_busy=5'b00011, ready=0 for 6 cycles -> spawn_valid=1, spawn_lane=2 stable; count increments once on ready; next spawn lane 3. lane_busy=5'b11111 -> no spawn_valid.
- Simultaneous kills/advance: after 5 spawns, zombie_killed=5'b10101 then 5'b01010 -> killed_count 3 then 5; next cycle state=NL2 (04h) and level_reset pulse; INTERMISSION=3 -> L2 (08h) after 3 ticks.
- Lose priority: in L3 with killed_count=4, zombie_killed=1 and zombie_reached_end=1 same cycle -> DoneL (40h), not DoneW; start -> I.
- Win path: complete L1, L2, L3 -> state=80h; kill/end pulses ignored; start returns to I with level_reset.

Source files
------------

// File: rtl/zombie_wave_scheduler.sv
// Game-level controller: level FSM, shared game tick, round-robin zombie spawn
// scheduling over valid/ready, and per-level kill accounting.
module zombie_wave_scheduler #(
  parameter int TICK_DIV          = 500000,
  parameter int GAP_L1            = 120,
  parameter int GAP_L2            = 80,
  parameter int GAP_L3            = 50,
  parameter int ZOMBIES_PER_LEVEL = 5,
  parameter int INTERMISSION      = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] lane_busy,
  input  logic [4:0] zombie_killed,
  input  logic       zombie_reached_end,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [2:0] spawn_lane,
  output logic       game_tick,
  output logic [7:0] state,
  output logic [2:0] spawned_count,
  output logic [2:0] killed_count,
  output logic       level_reset
);

  localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [2:0]     ZPL       = 3'(ZOMBIES_PER_LEVEL);
  localparam logic [8:0]     INTER     = 9'(INTERMISSION);

  localparam logic [7:0] S_I     = 8'b0000_0001;
  localparam logic [7:0] S_L1    = 8'b0000_0010;
  localparam logic [7:0] S_NL2   = 8'b0000_0100;
  localparam logic [7:0] S_L2    = 8'b0000_1000;
  localparam logic [7:0] S_NL3   = 8'b0001_0000;
  localparam logic [7:0] S_L3    = 8'b0010_0000;
  localparam logic [7:0] S_DONEL = 8'b0100_0000;
  localparam logic [7:0] S_DONEW = 8'b1000_0000;

  logic [7:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          game_tick_q, game_tick_d;
  logic [7:0]    gap_q, gap_d;
  logic [2:0]    spawned_q, spawned_d;
  logic [2:0]    killed_q, killed_d;
  logic          spawn_valid_q, spawn_valid_d;
  logic [2:0]    spawn_lane_q, spawn_lane_d;
  logic [2:0]    ptr_q, ptr_d;
  logic          level_reset_q, level_reset_d;

  logic          in_level, in_inter;
  logic [7:0]    gap_target;
  logic [2:0]    kill_cnt;
  logic [3:0]    kill_sum;
  logic [3:0]    cand;
  logic [7:0]    busy_ext;
  logic          found;
  logic [2:0]    sel_lane;

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < 5; i++) begin
      kill_cnt = kill_cnt + {2'b00, zombie_killed[i]};
    end
    kill_sum = {1'b0, killed_q} + {1'b0, kill_cnt};
  end

  // Round-robin search starting at ptr; unused upper slots read as busy.
  always_comb begin
    busy_ext = {3'b111, lane_busy};
    found    = 1'b0;
    sel_lane = '0;
    cand     = '0;
    for (int i = 0; i < 5; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!found && !busy_ext[cand[2:0]]) begin
        found    = 1'b1;
        sel_lane = cand[2:0];
      end
    end
  end

  always_comb begin
    case (state_q)
      S_L1:    gap_target = 8'(GAP_L1);
      S_L2:    gap_target = 8'(GAP_L2);
      S_L3:    gap_target = 8'(GAP_L3);
      default: gap_target = 8'hFF;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    spawned_d     = spawned_q;
    killed_d      = killed_q;
    spawn_valid_d = spawn_valid_q;
    spawn_lane_d  = spawn_lane_q;
    ptr_d         = ptr_q;
    level_reset_d = 1'b0;

    game_tick_d = (tick_cnt_q == TICK_LAST);
    tick_cnt_d  = game_tick_d ? '0 : tick_cnt_q + TW'(1);

    in_level = |(state_q & (S_L1 | S_L2 | S_L3));
    in_inter = |(state_q & (S_NL2 | S_NL3));

    case (state_q)
      S_I: if (start) state_d = S_L1;
      S_L1, S_L2, S_L3: begin
        if (zombie_reached_end) begin
          state_d = S_DONEL;
        end else if (killed_q == ZPL && spawned_q == ZPL) begin
          state_d = (state_q == S_L1) ? S_NL2 : (state_q == S_L2) ? S_NL3 : S_DONEW;
        end
      end
      S_NL2, S_NL3: begin
        if (start || (game_tick_q && ({1'b0, gap_q} + 9'd1 >= INTER))) begin
          state_d = (state_q == S_NL2) ? S_L2 : S_L3;
        end
      end
      S_DONEL, S_DONEW: if (start) state_d = S_I;
      default: state_d = S_I;
    endcase

    // Any state entry flushes per-level bookkeeping and any pending spawn.
    if (state_d != state_q) begin
      gap_d         = '0;
      spawned_d     = '0;
      killed_d      = '0;
      spawn_valid_d = 1'b0;
      level_reset_d = |(state_d & (S_I | S_NL2 | S_NL3 | S_DONEL | S_DONEW));
    end else if (in_level) begin
      killed_d = (kill_sum >= {1'b0, ZPL}) ? ZPL : kill_sum[2:0];
      if (spawn_valid_q && spawn_ready) begin
        spawn_valid_d = 1'b0;
        spawned_d     = spawned_q + 3'd1;
        gap_d         = '0;
        ptr_d         = (spawn_lane_q == 3'd4) ? 3'd0 : spawn_lane_q + 3'd1;
      end else if (game_tick_q && gap_q != 8'hFF) begin
        gap_d = gap_q + 8'd1;
      end
      if (!spawn_valid_q && gap_q >= gap_target && spawned_q < ZPL && found) begin
        spawn_valid_d = 1'b1;
        spawn_lane_d  = sel_lane;
      end
    end else if (in_inter) begin
      if (game_tick_q && gap_q != 8'hFF) gap_d = gap_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_I;
      tick_cnt_q    <= '0;
      game_tick_q   <= 1'b0;
      gap_q         <= '0;
      spawned_q     <= '0;
      killed_q      <= '0;
      spawn_valid_q <= 1'b0;
      spawn_lane_q  <= '0;
      ptr_q         <= '0;
      level_reset_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      game_tick_q   <= game_tick_d;
      gap_q         <= gap_d;
      spawned_q     <= spawned_d;
      killed_q      <= killed_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_lane_q  <= spawn_lane_d;
      ptr_q         <= ptr_d;
      level_reset_q <= level_reset_d;
    end
  end

  assign state         = state_q;
  assign game_tick     = game_tick_q;
  assign spawn_valid   = spawn_valid_q;
  assign spawn_lane    = spawn_lane_q;
  assign spawned_count = spawned_q;
  assign killed_count  = killed_q;
  assign level_reset   = level_reset_q;

endmodule

// File: tb/tb_zombie_wave_scheduler.sv
// Self-checking bench for zombie_wave_scheduler: directed vector table, hand
// sequences for backpressure and lose priority, and random traffic vs a model.
module tb_zombie_wave_scheduler;

  localparam int TD    = 4;
  localparam int G1    = 2;
  localparam int G2    = 3;
  localparam int G3    = 2;
  localparam int ZPL   = 5;
  localparam int INTER = 3;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] lane_busy;
  logic [4:0] zombie_killed;
  logic       zombie_reached_end;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [2:0] spawn_lane;
  logic       game_tick;
  logic [7:0] state;
  logic [2:0] spawned_count;
  logic [2:0] killed_count;
  logic       level_reset;

  int n_checks = 0;
  int n_fails  = 0;

  zombie_wave_scheduler #(
    .TICK_DIV(TD), .GAP_L1(G1), .GAP_L2(G2), .GAP_L3(G3),
    .ZOMBIES_PER_LEVEL(ZPL), .INTERMISSION(INTER)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .lane_busy(lane_busy),
    .zombie_killed(zombie_killed), .zombie_reached_end(zombie_reached_end),
    .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
    .game_tick(game_tick), .state(state), .spawned_count(spawned_count),
    .killed_count(killed_count), .level_reset(level_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: level index 0=I,1=L1,2=NL2,3=L2,4=NL3,5=L3,6=DoneL,7=DoneW.
  int m_level, m_tcnt, m_tick, m_gap, m_sp, m_kl, m_valid, m_lane, m_ptr, m_lr;

  task automatic modelStep();
    int nxt;
    int gap_goal;
    int ticks_now;
    bit want;
    if (reset) begin
      m_level = 0; m_tcnt = 0; m_tick = 0; m_gap = 0; m_sp = 0; m_kl = 0;
      m_valid = 0; m_lane = 0; m_ptr = 0; m_lr = 1;
      return;
    end
    nxt = m_level;
    ticks_now = m_gap + m_tick;
    case (m_level)
      0: if (start) nxt = 1;
      1, 3, 5: begin
        if (zombie_reached_end) nxt = 6;
        else if (m_kl == ZPL && m_sp == ZPL) nxt = (m_level == 5) ? 7 : m_level + 1;
      end
      2, 4: if (start || ticks_now >= INTER) nxt = m_level + 1;
      default: if (start) nxt = 0;
    endcase
    if (nxt != m_level) begin
      m_sp = 0; m_kl = 0; m_gap = 0; m_valid = 0;
      m_lr = (nxt == 1 || nxt == 3 || nxt == 5) ? 0 : 1;
      m_level = nxt;
    end else begin
      m_lr = 0;
      if (m_level == 1 || m_level == 3 || m_level == 5) begin
        gap_goal = (m_level == 1) ? G1 : (m_level == 3) ? G2 : G3;
        want = (m_valid == 0) && (m_gap >= gap_goal) && (m_sp < ZPL);
        m_kl = m_kl + $countones(zombie_killed);
        if (m_kl > ZPL) m_kl = ZPL;
        if (m_valid == 1 && spawn_ready) begin
          m_valid = 0;
          m_sp    = m_sp + 1;
          m_ptr   = (m_lane + 1) % 5;
          m_gap   = 0;
        end else if (m_tick == 1 && m_gap < 255) begin
          m_gap = m_gap + 1;
        end
        if (want) begin
          for (int i = 0; i < 5; i++) begin
            if (m_valid == 0 && !lane_busy[(m_ptr + i) % 5]) begin
              m_lane  = (m_ptr + i) % 5;
              m_valid = 1;
            end
          end
        end
      end else if (m_level == 2 || m_level == 4) begin
        if (m_tick == 1 && m_gap < 255) m_gap = m_gap + 1;
      end
    end
    m_tick = (m_tcnt == TD - 1) ? 1 : 0;
    m_tcnt = (m_tcnt + 1) % TD;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("state", int'(state), 1 << m_level);
    checkOutput("spawn_valid", int'(spawn_valid), m_valid);
    checkOutput("spawn_lane", int'(spawn_lane), m_lane);
    checkOutput("game_tick", int'(game_tick), m_tick);
    checkOutput("spawned_count", int'(spawned_count), m_sp);
    checkOutput("killed_count", int'(killed_count), m_kl);
    checkOutput("level_reset", int'(level_reset), m_lr);
  endtask

  // One clock: drive inputs, advance DUT and model together, compare after the edge.
  task automatic applyStimulus(input logic st, input logic [4:0] busy, input logic [4:0] kill,
                               input logic endp, input logic rdy);
    start = st; lane_busy = busy; zombie_killed = kill;
    zombie_reached_end = endp; spawn_ready = rdy;
    @(posedge clk);
    modelStep();
    #1;
    compareModel();
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic waitSpawned(input int target, input string name);
    int k;
    k = 0;
    while (int'(spawned_count) != target && k < 200) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
      k++;
    end
    checkOutput({name, "_timeout"}, int'(spawned_count), target);
  endtask

  task automatic waitValid(input logic [4:0] busy, input string name);
    int k;
    k = 0;
    while (!spawn_valid && k < 40) begin
      applyStimulus(1'b0, busy, 5'd0, 1'b0, 1'b0);
      k++;
    end
    checkOutput({name, "_timeout"}, int'(spawn_valid), 1);
  endtask

  task automatic completeLevel(input logic [7:0] next_state, input string name);
    waitSpawned(ZPL, name);
    applyStimulus(1'b0, 5'd0, 5'b11111, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    checkOutput({name, "_advance"}, int'(state), int'(next_state));
  endtask

  typedef struct {
    logic       st;
    logic [4:0] busy;
    logic [4:0] kill;
    logic       endp;
    logic       rdy;
    int         cycles;
    logic [7:0] exp_state;
    int         exp_spawned;
    int         exp_killed;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int tick_seen;
    int valid_seen;

    // Full win path with hand-derived end-of-phase expectations.
    vecs[0]  = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 3,  8'h01, 0, 0};
    vecs[1]  = '{1'b1, 5'd0, 5'd0,       1'b0, 1'b1, 1,  8'h02, 0, 0};
    vecs[2]  = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 70, 8'h02, 5, 0};
    vecs[3]  = '{1'b0, 5'd0, 5'b10101,   1'b0, 1'b1, 1,  8'h02, 5, 3};
    vecs[4]  = '{1'b0, 5'd0, 5'b01010,   1'b0, 1'b1, 1,  8'h02, 5, 5};
    vecs[5]  = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 1,  8'h04, 0, 0};
    vecs[6]  = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 14, 8'h08, 0, 0};
    vecs[7]  = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 90, 8'h08, 5, 0};
    vecs[8]  = '{1'b0, 5'd0, 5'b11111,   1'b0, 1'b1, 1,  8'h08, 5, 5};
    vecs[9]  = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 1,  8'h10, 0, 0};
    vecs[10] = '{1'b1, 5'd0, 5'd0,       1'b0, 1'b1, 1,  8'h20, 0, 0};
    vecs[11] = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 70, 8'h20, 5, 0};
    vecs[12] = '{1'b0, 5'd0, 5'b00111,   1'b0, 1'b1, 1,  8'h20, 5, 3};
    vecs[13] = '{1'b0, 5'd0, 5'b11000,   1'b0, 1'b1, 1,  8'h20, 5, 5};
    vecs[14] = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 1,  8'h80, 0, 0};
    vecs[15] = '{1'b0, 5'd0, 5'b11111,   1'b1, 1'b1, 3,  8'h80, 0, 0};
    vecs[16] = '{1'b1, 5'd0, 5'd0,       1'b0, 1'b1, 1,  8'h01, 0, 0};
    vecs[17] = '{1'b0, 5'd0, 5'd0,       1'b0, 1'b1, 2,  8'h01, 0, 0};

    reset = 1'b1; start = 1'b0; lane_busy = '0; zombie_killed = '0;
    zombie_reached_end = 1'b0; spawn_ready = 1'b0;

    // Reset values and tick period.
    doReset();
    checkOutput("rst_state", int'(state), 8'h01);
    checkOutput("rst_valid", int'(spawn_valid), 0);
    checkOutput("rst_spawned", int'(spawned_count), 0);
    checkOutput("rst_killed", int'(killed_count), 0);
    checkOutput("rst_level_reset", int'(level_reset), 1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_level_reset_drop", int'(level_reset), 0);
    tick_seen = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick_seen += int'(game_tick);
    end
    checkOutput("tick_count_40", tick_seen, 10);

    // Directed vector table.
    doReset();
    for (int v = 0; v < 18; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) begin
        applyStimulus(vecs[v].st, vecs[v].busy, vecs[v].kill, vecs[v].endp, vecs[v].rdy);
      end
      checkOutput($sformatf("vec%0d_state", v), int'(state), int'(vecs[v].exp_state));
      checkOutput($sformatf("vec%0d_spawned", v), int'(spawned_count), vecs[v].exp_spawned);
      checkOutput($sformatf("vec%0d_killed", v), int'(killed_count), vecs[v].exp_killed);
    end

    // Backpressure, busy-lane skipping and all-lanes-busy.
    doReset();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    waitValid(5'b00011, "bp_first");
    checkOutput("bp_lane_first", int'(spawn_lane), 2);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 5'b00011, 5'd0, 1'b0, 1'b0);
      checkOutput("bp_hold_lane", int'(spawn_lane), 2);
      checkOutput("bp_hold_valid", int'(spawn_valid), 1);
      checkOutput("bp_hold_count", int'(spawned_count), 0);
    end
    applyStimulus(1'b0, 5'b00011, 5'd0, 1'b0, 1'b1);
    checkOutput("bp_accept_count", int'(spawned_count), 1);
    checkOutput("bp_accept_valid", int'(spawn_valid), 0);
    waitValid(5'd0, "bp_second");
    checkOutput("bp_lane_second", int'(spawn_lane), 3);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    valid_seen = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 5'b11111, 5'd0, 1'b0, 1'b1);
      valid_seen += int'(spawn_valid);
    end
    checkOutput("allbusy_no_valid", valid_seen, 0);
    waitValid(5'd0, "bp_third");
    checkOutput("bp_lane_third", int'(spawn_lane), 4);

    // Lose beats simultaneous final kill in L3.
    doReset();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b1);
    completeLevel(8'h04, "lose_l1");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b1);
    completeLevel(8'h10, "lose_l2");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b1);
    checkOutput("lose_in_l3", int'(state), 8'h20);
    waitSpawned(ZPL, "lose_l3");
    applyStimulus(1'b0, 5'd0, 5'b01111, 1'b0, 1'b1);
    checkOutput("lose_killed4", int'(killed_count), 4);
    applyStimulus(1'b0, 5'd0, 5'b10000, 1'b1, 1'b1);
    checkOutput("lose_donel", int'(state), 8'h40);
    checkOutput("lose_level_reset", int'(level_reset), 1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    checkOutput("lose_stays", int'(state), 8'h40);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b1);
    checkOutput("lose_restart", int'(state), 8'h01);

    // Random traffic checked cycle-by-cycle against the model.
    doReset();
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      applyStimulus(($urandom_range(0, 15) == 0),
                    5'($urandom) & 5'($urandom),
                    ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0,
                    ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 1) == 1));
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
